// File: rtl/periph_bus_master.sv
// periph_bus_master: load/store initiator onto a word-wide peripheral register bus
// Byte and half stores run as read-modify-write; loads are lane-selected and extended.
module periph_bus_master #(
  parameter int WORD_ADDR_BITS = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_addr,
  output logic        bus_wr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);
  localparam int AW = WORD_ADDR_BITS + 2;
  typedef enum logic [2:0] {IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP} state_t;
  state_t state, next;
  logic [AW-1:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q, err_q, bad, busy;
  logic [31:0] wdata_q, merge_q, rdata_q, mask, merged, ext;
  logic [15:0] lane;
  logic [4:0]  sh;
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (req_addr >> AW) != 32'd0;
    sh = size_q == 2'b00 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    merged = (merge_q & ~mask) | ((wdata_q << sh) & mask);
    lane = 16'(bus_rdata >> sh);
    ext = size_q == 2'b10 ? bus_rdata :
          size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane} :
                            {{24{~uns_q & lane[7]}}, lane[7:0]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:   if (req_valid) next = bad ? RESP : !req_wr ? READ : req_size == 2'b10 ? WRITE : RMW_RD;
      READ:   next = RESP;
      RMW_RD: next = RMW_WR;
      RMW_WR: next = RESP;
      WRITE:  next = RESP;
      RESP:   if (resp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    busy = state == READ || state == RMW_RD || state == RMW_WR || state == WRITE;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    resp_rdata = resp_valid ? rdata_q : 32'd0;
    resp_err = resp_valid & err_q;
    bus_addr = busy ? 32'(addr_q[AW-1:2]) : 32'd0;
    bus_wr = state == RMW_WR || state == WRITE;
    bus_wdata = state == WRITE ? wdata_q : state == RMW_WR ? merged : 32'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr[AW-1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        err_q   <= bad;
        rdata_q <= '0;
      end
      if (state == READ) rdata_q <= ext;
      if (state == RMW_RD) merge_q <= bus_rdata;
    end
endmodule
